// File: rtl/traffic_pkg.sv
// Shared types and helpers for the traffic phase timer: phase and controller
// encodings, light decoding and per-phase duration lookup.
package traffic_pkg;

  typedef enum logic [2:0] {
    GR  = 3'd0,
    YR  = 3'd1,
    RR  = 3'd2,
    RG  = 3'd3,
    RY  = 3'd4,
    PED = 3'd5
  } phase_t;

  typedef enum logic [2:0] {
    SETTLE = 3'd0,
    LOAD   = 3'd1,
    COUNT  = 3'd2,
    STEP   = 3'd3,
    FAULT  = 3'd4
  } ctrl_t;

  typedef struct packed {
    phase_t phase;
    logic   legal;
  } decode_t;

  typedef struct packed {
    int unsigned gr;
    int unsigned yr;
    int unsigned rr;
    int unsigned rg;
    int unsigned ry;
    int unsigned ped;
  } durations_t;

  // Legal only when exactly one phase pattern matches and each street shows
  // exactly one lamp; anything else is an illegal combination.
  function automatic decode_t decode_phase(
    input logic mg,
    input logic my,
    input logic mr,
    input logic sg,
    input logic sy,
    input logic sr,
    input logic ped
  );
    decode_t    d;
    logic [5:0] hit;
    hit = {mr & sr & ped, mr & sy, mr & sg, mr & sr & ~ped, my & sr, mg & sr};
    case (hit)
      6'b000001: d.phase = GR;
      6'b000010: d.phase = YR;
      6'b000100: d.phase = RR;
      6'b001000: d.phase = RG;
      6'b010000: d.phase = RY;
      6'b100000: d.phase = PED;
      default:   d.phase = GR;
    endcase
    d.legal = ($countones(hit) == 1) &&
              ($countones({mg, my, mr}) == 1) &&
              ($countones({sg, sy, sr}) == 1);
    return d;
  endfunction

  // Side-green loads its maximum; gap-out can end it earlier.
  function automatic int unsigned phase_duration(input phase_t p, input durations_t d);
    int unsigned n;
    case (p)
      GR:      n = d.gr;
      YR:      n = d.yr;
      RR:      n = d.rr;
      RG:      n = d.rg;
      RY:      n = d.ry;
      PED:     n = d.ped;
      default: n = d.gr;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/traffic_phase_timer_tick_prescaler.sv
// Divides the system clock into one-cycle ticks; counts only while enabled
// and restarts from zero on clear.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase sequencer for the traffic light state machine: decodes the lit phase,
// times it in prescaled ticks and issues the single-cycle step that drives en.
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned CW       = 8,
  parameter int unsigned T_GR     = 20,
  parameter int unsigned T_YR     = 3,
  parameter int unsigned T_RR     = 2,
  parameter int unsigned T_SG_MAX = 15,
  parameter int unsigned T_SG_MIN = 4,
  parameter int unsigned T_SY     = 3,
  parameter int unsigned T_PED    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MG,
  input  logic          MY,
  input  logic          MR,
  input  logic          SG,
  input  logic          SY,
  input  logic          SR,
  input  logic          pedLight,
  input  logic          newCycle,
  input  logic          run,
  input  logic          adv,
  input  logic          sideCar,
  output logic          step,
  output phase_t        phase,
  output logic [CW-1:0] remaining,
  output logic          fault,
  output logic          flash,
  output logic [7:0]    cycleCount
);

  localparam durations_t DUR = '{
    gr:  T_GR,
    yr:  T_YR,
    rr:  T_RR,
    rg:  T_SG_MAX,
    ry:  T_SY,
    ped: T_PED
  };

  ctrl_t         r_state;
  ctrl_t         w_state_next;
  phase_t        r_phase;
  logic [CW-1:0] r_remaining;
  logic [CW-1:0] r_elapsed;
  logic          r_step;
  logic          r_fault;
  logic          r_flash;
  logic [7:0]    r_cycle_count;
  logic          r_sc_meta;
  logic          r_sc_sync;

  decode_t       w_dec;
  logic          w_tick;
  logic          w_pre_en;
  logic          w_pre_clr;
  logic          w_expire;
  logic          w_gap_out;
  logic          w_step_next;

  assign w_dec     = decode_phase(MG, MY, MR, SG, SY, SR, pedLight);
  assign w_expire  = w_tick && (r_remaining == CW'(1));
  assign w_gap_out = (r_phase == RG) && !r_sc_sync && (r_elapsed >= CW'(T_SG_MIN));

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (w_pre_clr),
    .en    (w_pre_en),
    .tick  (w_tick)
  );

  // Two-flop synchronizer for the asynchronous vehicle detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sc_meta <= 1'b0;
      r_sc_sync <= 1'b0;
    end else begin
      r_sc_meta <= sideCar;
      r_sc_sync <= r_sc_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SETTLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SETTLE:  w_state_next = LOAD;
      LOAD:    w_state_next = w_dec.legal ? COUNT : FAULT;
      COUNT:   if (w_expire || adv || w_gap_out) w_state_next = STEP;
      STEP:    w_state_next = SETTLE;
      FAULT:   w_state_next = FAULT;
      default: w_state_next = FAULT;
    endcase
  end

  // Coincident exit causes still land in a single STEP state, so one pulse.
  always_comb begin
    w_pre_en    = 1'b0;
    w_pre_clr   = 1'b0;
    w_step_next = 1'b0;
    case (r_state)
      LOAD:    w_pre_clr = 1'b1;
      COUNT:   w_pre_en  = run;
      FAULT:   w_pre_en  = 1'b1;
      default: ;
    endcase
    w_step_next = (w_state_next == STEP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step        <= 1'b0;
      r_phase       <= GR;
      r_remaining   <= '0;
      r_elapsed     <= '0;
      r_fault       <= 1'b0;
      r_flash       <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_step <= w_step_next;
      case (r_state)
        LOAD: begin
          if (newCycle) begin
            r_cycle_count <= r_cycle_count + 8'd1;
          end
          if (w_dec.legal) begin
            r_phase     <= w_dec.phase;
            r_remaining <= CW'(phase_duration(w_dec.phase, DUR));
            r_elapsed   <= '0;
          end else begin
            r_fault     <= 1'b1;
            r_remaining <= '0;
          end
        end
        COUNT: begin
          if (w_tick) begin
            r_remaining <= r_remaining - CW'(1);
            if (r_elapsed != {CW{1'b1}}) begin
              r_elapsed <= r_elapsed + CW'(1);
            end
          end
        end
        FAULT: begin
          r_fault     <= 1'b1;
          r_remaining <= '0;
          if (w_tick) begin
            r_flash <= ~r_flash;
          end
        end
        default: ;
      endcase
    end
  end

  assign step       = r_step;
  assign phase      = r_phase;
  assign remaining  = r_remaining;
  assign fault      = r_fault;
  assign flash      = r_flash;
  assign cycleCount = r_cycle_count;

endmodule

// File: doc/traffic_phase_timer.md
# traffic_phase_timer

Clock-domain sequencer for the traffic light state machine. It decodes the current phase from the light outputs, times each phase in prescaled ticks, and issues a one-cycle `step` pulse that drives the state machine's `en` input. It also supports side-street gap-out, a manual advance, a run/hold control and a sticky fault/flash mode for illegal light combinations. It sits between the system clock and the light state machine and is the only source of `en`.

## Interface
- `TICK_DIV`, 1000: clock cycles per tick; must be ≥1.
- `CW`, 8: width of the phase tick counter.
- `T_GR`, 20: main-green duration in ticks.
- `T_YR`, 3: main-yellow duration in ticks.
- `T_RR`, 2: all-red duration in ticks; used for both all-red phases.
- `T_SG_MAX`, 15: side-green maximum in ticks.
- `T_SG_MIN`, 4: side-green minimum before gap-out is allowed.
- `T_SY`, 3: side-yellow duration in ticks.
- `T_PED`, 10: pedestrian-walk duration in ticks.
- All durations must be ≥1 and fit in `CW` bits. `T_SG_MIN` ≤ `T_SG_MAX`.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: async, active-high.
- `MG`, `MY`, `MR`, `SG`, `SY`, `SR`, `pedLight` in 1 each: light outputs of the state machine.
- `newCycle` in 1: high while the state machine is in main-green.
- `run` in 1: when high, ticks count; when low, timing freezes.
- `adv` in 1: manual advance request, sampled in COUNT.
- `sideCar` in 1: side-street vehicle present; asynchronous, synchronized internally with 2 flops.
- `step` out 1: one-cycle pulse, connected to the state machine's `en`.
- `phase` out 3: decoded phase, `phase_t`.
- `remaining` out CW: ticks left in the current phase.
- `fault` out 1: sticky illegal-lights flag.
- `flash` out 1: toggles every tick while in FAULT.
- `cycleCount` out 8: count of completed full cycles; wraps.

## Operation
- Controller states: SETTLE, LOAD, COUNT, STEP, FAULT. The reset state is SETTLE.
- Reset values: `step`=0, `phase`=GR, `remaining`=0, `fault`=0, `flash`=0, `cycleCount`=0. The prescaler and both synchronizer flops reset to 0.
- **SETTLE** lasts 1 cycle so the light outputs can settle after an `en` edge. It always goes to LOAD.
- **LOAD** decodes the phase from the lights:
  - GR = MG&SR
  - YR = MY&SR
  - RR = MR&SR&~pedLight
  - RG = MR&SG
  - RY = MR&SY
  - PED = MR&SR&pedLight
  - Any other combination (none matching or several lit) goes to FAULT.
- On a legal decode, LOAD writes `phase`, loads `remaining` with the phase duration, clears the prescaler and the elapsed-tick counter, and goes to COUNT.
- If `newCycle`=1 during LOAD, `cycleCount` increments (8-bit wrap).
- **COUNT** behaviour:
  - The prescaler advances only while `run`=1. A tick fires when the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
  - On each tick, `remaining` decrements and the elapsed counter increments (the elapsed counter saturates at 2^CW-1).
  - Exit to STEP when any of the following holds:
    - a tick occurs with `remaining`==1;
    - `adv`=1;
    - `phase`==RG, synchronized `sideCar`=0, and elapsed ≥ T_SG_MIN (gap-out).
  - If several exit conditions coincide, exactly one step is issued.
  - When `run`=0: the prescaler and `remaining` hold and ticks are suppressed. `adv` still forces STEP.
- **STEP** drives `step`=1 for exactly one cycle, then goes to SETTLE. It completes regardless of `run`.
- **FAULT** is absorbing until reset:
  - `step` is held at 0.
  - `fault`=1.
  - `flash` toggles on each tick (the prescaler runs regardless of `run`).
  - `remaining` holds 0.
- Asserting `reset` mid-phase returns immediately to the reset values. `step` drops asynchronously.

## Timing
- `step` is a registered output, so there are no glitches on `en`.
- With `run` held at 1 and no early exit, a phase of N ticks, with LOAD at cycle t, gives:
  - Nth tick at cycle t+N·TICK_DIV;
  - `step` high at cycle t+N·TICK_DIV+1;
  - SETTLE at t+N·TICK_DIV+2;
  - next LOAD at t+N·TICK_DIV+3.
  - The total phase period is N·TICK_DIV+3 cycles.
- `adv` sampled high in COUNT at cycle c gives `step` at c+1.
- `sideCar` has 2 cycles of synchronizer latency. The gap-out decision uses the synchronized value, so `step` comes 1 cycle after the qualifying cycle.
- `phase`, `remaining` and `cycleCount` update on the cycle after LOAD.

## Structure
- Package `traffic_pkg`:
  - `phase_t` enum: GR, YR, RR, RG, RY, PED;
  - `ctrl_t` enum for the controller states;
  - the `decode_phase` function (lights to phase plus a legal bit);
  - a duration lookup function taking `phase_t`.
- Sub-module `tick_prescaler`:
  - parameter TICK_DIV;
  - inputs `clk`, `reset`, `clr`, `en`;
  - output `tick`.
- All remaining logic stays in one module with a single registered FSM.

## Test plan
- TICK_DIV=4, T_GR=2, `run`=1, lights = GR → `step` exactly 1 cycle at LOAD+9; `phase`=GR; `remaining` goes 2→1→0; `cycleCount` becomes 1.
- Full loop with the light state machine attached, `pedButton` pulsed during RG → phases GR, YR, RR, RG, RY, RR, PED, GR in order; each period is N·4+3 cycles.
- RG phase, `sideCar`=0, T_SG_MIN=4, T_SG_MAX=15 → `step` after the 4th tick plus 1 cycle. With `sideCar`=1 throughout → `step` after the 15th tick.
- `run` dropped at `remaining`=3 for 50 cycles, then raised → `remaining` stays 3 and the phase end is delayed by exactly 50 cycles. `adv` pulsed during the hold → `step` on the next cycle.
- Lights forced to MG&SG → FAULT; `fault`=1; `step` never asserts; `flash` toggles every 4 cycles. Asserting `reset` → all outputs return to their reset values.
- `adv` asserted in the same cycle as the final tick → exactly one `step` pulse.
